trivium_seq: RTL and testbench

Session sequencer for the Trivium stream-cipher datapath and its output FIFO. It loads the key and IV serially into the cipher core, waits out the warm-up rounds, and paces plaintext bytes into the core with backpressure from the FIFO condition flags. It also drains ciphertext from the FIFO into a valid/ready output register. It sits between the host bus and the cipher/FIFO pair and owns every strobe and read they receive.

---
 rtl/trivium_seq.sv | 199 +++++++++++++++++++
 tb/tb_trivium_seq.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trivium_seq.sv
// -----------------------------------------------------------------------------
// trivium_seq
//
// Session sequencer for the Trivium cipher core and its ciphertext FIFO.
// A session serially loads {key, IV} into the core and waits out the warm-up
// rounds. It then paces plaintext bytes into the core under FIFO-full
// backpressure and drains ciphertext from the FIFO into a valid/ready output
// register. The session ends with a one-cycle done pulse once everything has
// been delivered.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start, abort      session start pulse (IDLE only), synchronous abort
//   key_in, iv_in     key / IV captured on an accepted start
//   msg_len           plaintext byte count captured on an accepted start
//   in_data/valid/ready   plaintext byte stream from the host
//   key, strob_key    serial key/IV bit and its strobe to the core
//   data, strob_data  plaintext byte and its strobe to the core
//   fifo_cnd          FIFO flags: bit0 = full, bit1 = empty
//   read              FIFO read request (one-cycle pulse)
//   fifo_dout, read_stb   FIFO read data and its valid strobe
//   out_data/valid/ready  ciphertext output register handshake
//   busy, done        session active, session completion pulse
// -----------------------------------------------------------------------------
module trivium_seq #(
   parameter int KEY_W      = 80,
   parameter int IV_W       = 80,
   parameter int WARMUP_CYC = 1152,
   parameter int LEN_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [KEY_W-1:0] key_in,
   input  logic [IV_W-1:0]  iv_in,
   input  logic [LEN_W-1:0] msg_len,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             key,
   output logic             strob_key,
   output logic [7:0]       data,
   output logic             strob_data,
   input  logic [1:0]       fifo_cnd,
   output logic             read,
   input  logic [7:0]       fifo_dout,
   input  logic             read_stb,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done
);

   localparam int SH_W    = KEY_W + IV_W;
   localparam int CNT_MAX = (SH_W > WARMUP_CYC) ? SH_W : WARMUP_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(SH_W - 1);
   localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WARM,
      S_RUN,
      S_DRAIN
   } state_t;

   state_t           state;
   logic [SH_W-1:0]  shift_q;
   logic [CNT_W-1:0] cnt;
   logic [LEN_W-1:0] remain;
   logic             rd_pend;

   logic in_hs;
   logic drain_on;
   logic out_hs;
   logic drain_done;

   // Plaintext path is a combinational pass-through so a byte reaches the
   // core in the cycle it is accepted; full backpressure acts the same cycle.
   assign in_ready   = (state == S_RUN) && !fifo_cnd[0];
   assign in_hs      = in_ready && in_valid;
   assign strob_data = in_hs;
   assign data       = in_hs ? in_data : 8'd0;
   assign busy       = (state != S_IDLE);

   assign drain_on = (state == S_RUN) || (state == S_DRAIN);
   assign out_hs   = out_valid && out_ready;

   // Counting a handshake in progress lets done follow the final consumer
   // handshake by exactly one cycle.
   assign drain_done = (state == S_DRAIN) && fifo_cnd[1] && !rd_pend &&
                       (!out_valid || out_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         shift_q   <= '0;
         cnt       <= '0;
         remain    <= '0;
         rd_pend   <= 1'b0;
         key       <= 1'b0;
         strob_key <= 1'b0;
         read      <= 1'b0;
         out_data  <= 8'd0;
         out_valid <= 1'b0;
         done      <= 1'b0;
      end else if (abort) begin
         // Clearing rd_pend makes any read_stb still in flight harmless.
         state     <= S_IDLE;
         shift_q   <= '0;
         cnt       <= '0;
         remain    <= '0;
         rd_pend   <= 1'b0;
         key       <= 1'b0;
         strob_key <= 1'b0;
         read      <= 1'b0;
         out_data  <= 8'd0;
         out_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         read <= 1'b0;
         done <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start) begin
                  // The MSB goes out directly; the register keeps the rest.
                  shift_q   <= {key_in, iv_in} << 1;
                  key       <= key_in[KEY_W-1];
                  strob_key <= 1'b1;
                  cnt       <= '0;
                  remain    <= msg_len;
                  state     <= S_LOAD;
               end
            end

            S_LOAD: begin
               if (cnt == LOAD_LAST) begin
                  strob_key <= 1'b0;
                  key       <= 1'b0;
                  cnt       <= '0;
                  state     <= S_WARM;
               end else begin
                  key     <= shift_q[SH_W-1];
                  shift_q <= shift_q << 1;
                  cnt     <= cnt + 1'b1;
               end
            end

            S_WARM: begin
               if (cnt == WARM_LAST) begin
                  cnt   <= '0;
                  state <= (remain == '0) ? S_DRAIN : S_RUN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_RUN: begin
               if (in_hs) begin
                  remain <= remain - 1'b1;
                  if (remain == LEN_W'(1)) begin
                     state <= S_DRAIN;
                  end
               end
            end

            S_DRAIN: begin
               if (drain_done) begin
                  done  <= 1'b1;
                  state <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase

         // Drain engine: at most one outstanding read, and only into an
         // empty output register, so read_stb never collides with out_ready.
         if (drain_on) begin
            if (!fifo_cnd[1] && !out_valid && !rd_pend) begin
               read    <= 1'b1;
               rd_pend <= 1'b1;
            end
            if (read_stb && rd_pend) begin
               out_data  <= fifo_dout;
               out_valid <= 1'b1;
               rd_pend   <= 1'b0;
            end else if (out_hs) begin
               out_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_trivium_seq.sv
// -----------------------------------------------------------------------------
// tb_trivium_seq
//
// Bench for trivium_seq. A behavioural FIFO stub stands in for the cipher
// core and its FIFO: every byte strobed into the core is pushed into the stub
// as (byte ^ 8'h3C), and the stub answers each read one cycle later.
// Expected plaintext and ciphertext bytes are queued when a byte is driven and
// are popped when the DUT strobes it or hands it out.
// -----------------------------------------------------------------------------
module tb_trivium_seq;

   localparam int KEY_W      = 80;
   localparam int IV_W       = 80;
   localparam int WARMUP_CYC = 1152;
   localparam int LEN_W      = 16;
   localparam int SH_W       = KEY_W + IV_W;
   localparam int RUN_LAT    = 1 + SH_W + WARMUP_CYC;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             abort;
   logic [KEY_W-1:0] key_in;
   logic [IV_W-1:0]  iv_in;
   logic [LEN_W-1:0] msg_len;
   logic [7:0]       in_data;
   logic             in_valid;
   logic             in_ready;
   logic             key;
   logic             strob_key;
   logic [7:0]       data;
   logic             strob_data;
   logic [1:0]       fifo_cnd;
   logic             read;
   logic [7:0]       fifo_dout;
   logic             read_stb;
   logic [7:0]       out_data;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             done;

   always #5 clk = ~clk;

   trivium_seq #(
      .KEY_W(KEY_W), .IV_W(IV_W), .WARMUP_CYC(WARMUP_CYC), .LEN_W(LEN_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .key_in(key_in), .iv_in(iv_in), .msg_len(msg_len),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .key(key), .strob_key(strob_key), .data(data), .strob_data(strob_data),
      .fifo_cnd(fifo_cnd), .read(read), .fifo_dout(fifo_dout), .read_stb(read_stb),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic flag(input string nm);
      total++;
      bad++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endtask

   // ---------------- FIFO stub and scoreboard state ----------------
   logic [7:0] fifo_q[$];
   logic [7:0] exp_in_q[$];
   logic [7:0] exp_out_q[$];
   logic       full_force = 1'b0;
   logic       fq_empty   = 1'b1;
   logic       rd_prev    = 1'b0;
   int         rdy_mode   = 1;   // 0 hold low, 1 always high, 2 toggle

   assign fifo_cnd = {fq_empty, full_force};

   int rd_cnt, key_cnt, sd_cnt, hs_cnt, done_cnt;
   int first_key, last_key, first_sd, last_hs, done_cyc;
   logic [SH_W-1:0] key_bits;

   initial begin
      read_stb  = 1'b0;
      fifo_dout = 8'd0;
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         read_stb = 1'b0;
         if (rd_prev) begin
            if (fifo_q.size() == 0) begin
               flag("fifo_read_while_empty");
            end else begin
               fifo_dout = fifo_q.pop_front();
               read_stb  = 1'b1;
            end
         end
         rd_prev = read;
         if (read) rd_cnt++;
         fq_empty = (fifo_q.size() == 0);
         case (rdy_mode)
            0:       out_ready = 1'b0;
            2:       out_ready = ~out_ready;
            default: out_ready = 1'b1;
         endcase
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (strob_key) begin
            key_cnt++;
            key_bits = {key_bits[SH_W-2:0], key};
            if (first_key < 0) first_key = cyc;
            last_key = cyc;
         end
         if (strob_data) begin
            if (first_sd < 0) first_sd = cyc;
            sd_cnt++;
            if (exp_in_q.size() == 0) flag("unexpected_strob_data");
            else chk("data", data, exp_in_q.pop_front());
            fifo_q.push_back(data ^ 8'h3C);
            fq_empty = 1'b0;
         end
         if (out_valid && out_ready) begin
            hs_cnt++;
            last_hs = cyc;
            if (exp_out_q.size() == 0) flag("unexpected_out_handshake");
            else chk("out_data", out_data, exp_out_q.pop_front());
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("busy_with_done", busy, 1'b0);
         end
      end
   end

   // ---------------- session vectors ----------------
   typedef struct {
      logic [KEY_W-1:0] k;
      logic [IV_W-1:0]  v;
      logic [LEN_W-1:0] len;
      logic [31:0]      bytes;     // byte i at bits [31-8i -: 8]
      int               stall_at;  // byte index held 5 cycles under full, -1 none
      int               rdy;       // out_ready mode
      int               exp_nkey;  // expected strob_key cycles
      int               exp_sd_lat; // cycles from start to first strob_data, -1 none
      int               exp_done_lat; // cycles from start to done, -1 = handshake based
   } vec_t;

   vec_t vecs[4];

   task automatic clear_counters();
      rd_cnt = 0; key_cnt = 0; sd_cnt = 0; hs_cnt = 0; done_cnt = 0;
      first_key = -1; last_key = -1; first_sd = -1; last_hs = -1; done_cyc = -1;
      key_bits = '0;
   endtask

   task automatic present(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      exp_in_q.push_back(b);
      exp_out_q.push_back(b ^ 8'h3C);
   endtask

   task automatic run_session(input vec_t v);
      int t0;
      int n;
      clear_counters();
      @(posedge clk);
      #1;
      key_in   = v.k;
      iv_in    = v.v;
      msg_len  = v.len;
      rdy_mode = v.rdy;
      start    = 1'b1;
      t0       = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < int'(v.len); i++) begin
         present(v.bytes[31-8*i -: 8]);
         if (i == v.stall_at) begin
            full_force = 1'b1;
            for (int c = 0; c < 5; c++) begin
               @(negedge clk);
               chk("stall_in_ready", in_ready, 1'b0);
               chk("stall_strob_data", strob_data, 1'b0);
               @(posedge clk);
               #1;
            end
            full_force = 1'b0;
         end
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!(in_valid && in_ready) && n < 3000);
         if (n >= 3000) begin
            flag("timeout_byte_accept");
            in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      if (v.len != 0) begin
         in_data = 8'hEE;
         @(negedge clk);
         chk("in_ready_after_last", in_ready, 1'b0);
         chk("no_strob_after_last", strob_data, 1'b0);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
      n = 0;
      while (done_cnt == 0 && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 5000) begin
         flag("timeout_done");
         return;
      end
      chk("strob_key_count", key_cnt, v.exp_nkey);
      chk("key_serial_bits", key_bits, {v.k, v.v});
      chk("first_strob_key", first_key, t0 + 1);
      chk("last_strob_key", last_key, t0 + v.exp_nkey);
      chk("first_strob_data", first_sd, (v.exp_sd_lat < 0) ? -1 : t0 + v.exp_sd_lat);
      chk("strob_data_count", sd_cnt, v.len);
      chk("read_count", rd_cnt, v.len);
      chk("out_hs_count", hs_cnt, v.len);
      if (v.exp_done_lat >= 0) chk("done_cycle", done_cyc, t0 + v.exp_done_lat);
      else chk("done_after_last_hs", done_cyc, last_hs + 1);
      chk("done_pulse_count", done_cnt, 1);
      chk("busy_after_done", busy, 1'b0);
      chk("exp_in_left", exp_in_q.size(), 0);
      chk("exp_out_left", exp_out_q.size(), 0);
      rdy_mode = 1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_in_ready"},   in_ready,   1'b0);
      chk({tag, "_key"},        key,        1'b0);
      chk({tag, "_strob_key"},  strob_key,  1'b0);
      chk({tag, "_data"},       data,       8'd0);
      chk({tag, "_strob_data"}, strob_data, 1'b0);
      chk({tag, "_read"},       read,       1'b0);
      chk({tag, "_out_data"},   out_data,   8'd0);
      chk({tag, "_out_valid"},  out_valid,  1'b0);
      chk({tag, "_busy"},       busy,       1'b0);
      chk({tag, "_done"},       done,       1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog_expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      vecs[0] = '{80'h0123456789ABCDEF0123, 80'hFEDCBA9876543210FEDC, 16'd4,
                  32'hA55A00FF, -1, 1, SH_W, RUN_LAT, -1};
      vecs[1] = '{80'h80000000000000000001, 80'h00000000000000000001, 16'd4,
                  32'h11223344, 2, 1, SH_W, RUN_LAT, -1};
      vecs[2] = '{80'hC0FFEE123456789ABCDE, 80'h5555AAAA5555AAAA5555, 16'd3,
                  32'hC33C7E00, -1, 2, SH_W, RUN_LAT, -1};
      vecs[3] = '{80'hDEADBEEF00112233AABB, 80'h0F0F0F0F0F0F0F0F0F0F, 16'd0,
                  32'h00000000, -1, 1, SH_W, -1, RUN_LAT + 1};

      rst      = 1'b1;
      start    = 1'b0;
      abort    = 1'b0;
      key_in   = '0;
      iv_in    = '0;
      msg_len  = '0;
      in_data  = 8'd0;
      in_valid = 1'b0;
      clear_counters();
      repeat (2) @(negedge clk);
      chk_idle_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 4; i++) run_session(vecs[i]);

      // Abort during warm-up, then a full session must follow.
      @(posedge clk);
      #1;
      key_in  = vecs[0].k;
      iv_in   = vecs[0].v;
      msg_len = 16'd2;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (300) @(posedge clk);
      #1;
      chk("warm_busy_before_abort", busy, 1'b1);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      chk_idle_outputs("abort");
      run_session(vecs[1]);

      // Asynchronous reset mid-RUN while a ciphertext byte is held.
      clear_counters();
      @(posedge clk);
      #1;
      key_in   = vecs[2].k;
      iv_in    = vecs[2].v;
      msg_len  = 16'd4;
      rdy_mode = 0;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      present(8'h96);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(in_valid && in_ready) && n < 3000);
      if (n >= 3000) flag("timeout_rst_byte");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("out_valid_before_rst", out_valid, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk_idle_outputs("async_rst");
      exp_in_q.delete();
      exp_out_q.delete();
      fifo_q.delete();
      rd_prev  = 1'b0;
      fq_empty = 1'b1;
      rdy_mode = 1;
      #1;
      rst = 1'b0;
      run_session(vecs[2]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
